// File: rtl/mem_ctrl.sv
// mem_ctrl: load/store controller between the CPU memory stage and a
// 32-bit x 2^WORDS_LOG2 word data SRAM. One request per handshake, checked
// for alignment/range, sub-word stores done as read-modify-write in a single
// ACCESS cycle using the SRAM's combinational read port.
module mem_ctrl #(
  parameter int WORDS_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [WORDS_LOG2-1:0] read1_addr,
  input  logic [31:0]           read1_data,
  output logic [WORDS_LOG2-1:0] read2_addr,
  output logic [WORDS_LOG2-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic        we_q, sgn_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        err_d;
  logic [31:0] load_d, merge_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(read1_data >> {addr_q[1:0], 3'b000});
  assign half_sel = addr_q[1] ? read1_data[31:16] : read1_data[15:0];

  // Request legality: illegal size, misalignment, or beyond the SRAM byte range.
  always_comb begin
    err_d = (size_q == 2'b11)
          | ((size_q == 2'b01) & addr_q[0])
          | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
          | (|addr_q[31:WORDS_LOG2+2]);
  end

  // Lane extraction with sign/zero extension for loads.
  always_comb begin
    load_d = 32'h0;
    case (size_q)
      2'b00:   load_d = sgn_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   load_d = sgn_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      2'b10:   load_d = read1_data;
      default: load_d = 32'h0;
    endcase
  end

  // Store merge: old word with the addressed lanes replaced by right-aligned wdata.
  always_comb begin
    merge_d = read1_data;
    case (size_q)
      2'b00: merge_d[addr_q[1:0]*8 +: 8] = wdata_q[7:0];
      2'b01: merge_d[addr_q[1]*16 +: 16] = wdata_q[15:0];
      2'b10: merge_d = wdata_q;
      default: merge_d = read1_data;
    endcase
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign read1_addr   = addr_q[WORDS_LOG2+1:2];
  assign write_addr   = addr_q[WORDS_LOG2+1:2];
  assign read2_addr   = '0;
  // The write strobe is purely a function of the registered state so an
  // async reset during ACCESS kills it immediately.
  assign write_enable = (state_q == ACCESS) & we_q & ~err_d;
  assign write_data   = write_enable ? merge_d : 32'h0;

  // Controller FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          sgn_q   <= req_signed;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          state_q <= ACCESS;
        end
        ACCESS: begin
          err_q   <= err_d;
          rdata_q <= (err_d | we_q) ? 32'h0 : load_d;
          state_q <= RESP;
        end
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
